// File: rtl/lc3_mem_arbiter.sv
// lc3_mem_arbiter
// Shares one single-ported unified memory between the LC3 fetch stage and the
// memory-access stage. Each access is granted in IDLE, held in ACC_I/ACC_D
// until the memory reports mem_rdy, and finished by one RESP cycle. During
// RESP the matching completion strobe is high.
//
// Optional feature: define LC3_ARB_TIMEOUT_EN to abort accesses that wait
// TIMEOUT_CYCLES access cycles without mem_rdy. An aborted access completes
// with 16'hFFFF and sets the sticky arb_err flag.
//
// Ports
//   clock, reset                     clock, synchronous active-high reset
//   instrmem_rd, pc                  fetch request (level) and address
//   Instr_dout, complete_instr       fetched word (held) and done pulse
//   data_req, Data_rd, Data_addr,
//   Data_din                         data request, direction, address, write data
//   Data_dout, complete_data         read data (reads only) and done pulse
//   mem_en, mem_we, mem_addr,
//   mem_wdata                        memory-side request (all registered)
//   mem_rdata, mem_rdy               memory-side response
//   arb_err                          sticky timeout flag (0 without the feature)
module lc3_mem_arbiter #(
    parameter int MAX_DATA_STREAK = 4,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        instrmem_rd,
    input  logic [15:0] pc,
    output logic [15:0] Instr_dout,
    output logic        complete_instr,
    input  logic        data_req,
    input  logic        Data_rd,
    input  logic [15:0] Data_addr,
    input  logic [15:0] Data_din,
    output logic [15:0] Data_dout,
    output logic        complete_data,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_rdy,
    output logic        arb_err
);

    typedef enum logic [1:0] {IDLE, ACC_I, ACC_D, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  streak_q, streak_d;
    logic        rd_q, rd_d;
    logic        en_q, en_d;
    logic        we_q, we_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] data_q, data_d;
    logic        ci_q, ci_d;
    logic        cd_q, cd_d;
    logic        fetch_starved;
`ifdef LC3_ARB_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;
`endif

    // A pending fetch beats data only once data has won MAX_DATA_STREAK times in a row.
    assign fetch_starved = instrmem_rd && (streak_q == 4'(MAX_DATA_STREAK));

    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        rd_d     = rd_q;
        en_d     = en_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        instr_d  = instr_q;
        data_d   = data_q;
        ci_d     = ci_q;
        cd_d     = cd_q;
`ifdef LC3_ARB_TIMEOUT_EN
        cnt_d    = cnt_q;
        err_d    = err_q;
`endif
        case (state_q)
            IDLE: begin
                ci_d = 1'b0;
                cd_d = 1'b0;
`ifdef LC3_ARB_TIMEOUT_EN
                cnt_d = 16'h0000;
`endif
                if (data_req && !fetch_starved) begin
                    state_d = ACC_D;
                    en_d    = 1'b1;
                    we_d    = !Data_rd;
                    addr_d  = Data_addr;
                    wdata_d = Data_din;
                    rd_d    = Data_rd;
                    // The streak only counts data wins that kept a fetch waiting.
                    if (!instrmem_rd) begin
                        streak_d = 4'h0;
                    end else if (streak_q != 4'hF) begin
                        streak_d = streak_q + 4'h1;
                    end
                end else if (instrmem_rd) begin
                    state_d  = ACC_I;
                    en_d     = 1'b1;
                    we_d     = 1'b0;
                    addr_d   = pc;
                    streak_d = 4'h0;
                end
            end
            ACC_I, ACC_D: begin
                if (mem_rdy) begin
                    if (state_q == ACC_I) begin
                        instr_d = mem_rdata;
                    end else if (rd_q) begin
                        data_d = mem_rdata;
                    end
                    ci_d    = (state_q == ACC_I);
                    cd_d    = (state_q == ACC_D);
                    en_d    = 1'b0;
                    we_d    = 1'b0;
                    state_d = RESP;
                end
`ifdef LC3_ARB_TIMEOUT_EN
                else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
                    // This is the last allowed access cycle: abort with a poison value.
                    if (state_q == ACC_I) begin
                        instr_d = 16'hFFFF;
                    end else if (rd_q) begin
                        data_d = 16'hFFFF;
                    end
                    ci_d    = (state_q == ACC_I);
                    cd_d    = (state_q == ACC_D);
                    en_d    = 1'b0;
                    we_d    = 1'b0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 16'h0001;
                end
`endif
            end
            default: begin
                // RESP: completion pulse visible for exactly this cycle.
                ci_d    = 1'b0;
                cd_d    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            streak_q <= 4'h0;
            rd_q     <= 1'b0;
            en_q     <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 16'h0000;
            wdata_q  <= 16'h0000;
            instr_q  <= 16'h0000;
            data_q   <= 16'h0000;
            ci_q     <= 1'b0;
            cd_q     <= 1'b0;
`ifdef LC3_ARB_TIMEOUT_EN
            cnt_q    <= 16'h0000;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            rd_q     <= rd_d;
            en_q     <= en_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            instr_q  <= instr_d;
            data_q   <= data_d;
            ci_q     <= ci_d;
            cd_q     <= cd_d;
`ifdef LC3_ARB_TIMEOUT_EN
            cnt_q    <= cnt_d;
            err_q    <= err_d;
`endif
        end
    end

    assign mem_en         = en_q;
    assign mem_we         = we_q;
    assign mem_addr       = addr_q;
    assign mem_wdata      = wdata_q;
    assign Instr_dout     = instr_q;
    assign Data_dout      = data_q;
    assign complete_instr = ci_q;
    assign complete_data  = cd_q;
`ifdef LC3_ARB_TIMEOUT_EN
    assign arb_err        = err_q;
`else
    assign arb_err        = 1'b0;
`endif

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Testbench for lc3_mem_arbiter: directed scenarios with literal expectations,
// then randomized requesters and memory, all checked every cycle against a
// transaction-level model of the arbiter.
module tb_lc3_mem_arbiter;

    localparam int MAXS = 4;
    localparam int TMO  = 64;
`ifdef LC3_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        instrmem_rd = 1'b0;
    logic [15:0] pc = 16'h0000;
    logic [15:0] Instr_dout;
    logic        complete_instr;
    logic        data_req = 1'b0;
    logic        Data_rd = 1'b0;
    logic [15:0] Data_addr = 16'h0000;
    logic [15:0] Data_din = 16'h0000;
    logic [15:0] Data_dout;
    logic        complete_data;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = 16'h0000;
    logic        mem_rdy = 1'b0;
    logic        arb_err;

    int n_tests = 0;
    int n_fail  = 0;

    lc3_mem_arbiter #(.MAX_DATA_STREAK(MAXS), .TIMEOUT_CYCLES(TMO)) dut (
        .clock(clock), .reset(reset),
        .instrmem_rd(instrmem_rd), .pc(pc),
        .Instr_dout(Instr_dout), .complete_instr(complete_instr),
        .data_req(data_req), .Data_rd(Data_rd), .Data_addr(Data_addr),
        .Data_din(Data_din), .Data_dout(Data_dout), .complete_data(complete_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_rdy(mem_rdy), .arb_err(arb_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // One access in flight at most; "busy" while the memory owes a response,
    // "showing" while the completion of the last access is visible.
    bit          t_busy = 0, t_showing = 0, t_fetch = 0, t_read = 0;
    int          t_waited = 0;
    int          data_wins_over_waiting_fetch = 0;
    logic        e_en = 0, e_we = 0, e_ci = 0, e_cd = 0, e_err = 0;
    logic [15:0] e_addr = 0, e_wdata = 0, e_instr = 0, e_data = 0;

    task automatic model_finish(input logic [15:0] val, input bit aborted);
        if (t_fetch) e_instr = val;
        else if (t_read) e_data = val;
        e_ci = t_fetch;
        e_cd = !t_fetch;
        e_en = 0;
        e_we = 0;
        if (aborted) e_err = 1;
        t_busy = 0;
        t_showing = 1;
    endtask

    task automatic model_edge();
        bit fetch_wins;
        if (reset) begin
            t_busy = 0; t_showing = 0; data_wins_over_waiting_fetch = 0;
            e_en = 0; e_we = 0; e_ci = 0; e_cd = 0; e_err = 0;
            e_addr = 0; e_wdata = 0; e_instr = 0; e_data = 0;
        end else if (t_showing) begin
            t_showing = 0;
            e_ci = 0;
            e_cd = 0;
        end else if (t_busy) begin
            if (mem_rdy) begin
                model_finish(mem_rdata, 0);
            end else begin
                t_waited++;
                if (TO_EN && t_waited >= TMO) model_finish(16'hFFFF, 1);
            end
        end else if (instrmem_rd || data_req) begin
            fetch_wins = instrmem_rd && (!data_req || data_wins_over_waiting_fetch >= MAXS);
            t_busy = 1;
            t_waited = 0;
            t_fetch = fetch_wins;
            e_en = 1;
            if (fetch_wins) begin
                e_addr = pc;
                e_we = 0;
                data_wins_over_waiting_fetch = 0;
            end else begin
                e_addr = Data_addr;
                e_wdata = Data_din;
                t_read = Data_rd;
                e_we = !Data_rd;
                data_wins_over_waiting_fetch = instrmem_rd ?
                    ((data_wins_over_waiting_fetch < 15) ? data_wins_over_waiting_fetch + 1 : 15) : 0;
            end
        end
    endtask

    always @(posedge clock) begin
        model_edge();
        #1;
        check("mem_en", mem_en, e_en);
        check("mem_we", mem_we, e_we);
        check("complete_instr", complete_instr, e_ci);
        check("complete_data", complete_data, e_cd);
        check("arb_err", arb_err, e_err);
        check("Instr_dout", Instr_dout, e_instr);
        check("Data_dout", Data_dout, e_data);
        if (e_en) check("mem_addr", mem_addr, e_addr);
        if (e_en && !t_fetch) check("mem_wdata", mem_wdata, e_wdata);
    end

    // ---------------- stimulus ----------------
    initial begin
        int we_cycles, pulses, n_done, en_cycles;
        bit done;
        logic [9:0] order;

        repeat (3) @(negedge clock);
        check("rst_mem_en", mem_en, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_complete", {complete_instr, complete_data}, 2'b00);
        check("rst_arb_err", arb_err, 1'b0);
        check("rst_outputs", {mem_addr, mem_wdata}, 32'h0);
        check("rst_douts", {Instr_dout, Data_dout}, 32'h0);
        reset = 1'b0;
        $display("[TB] txn reset done");

        // Fetch only
        instrmem_rd = 1; pc = 16'h3000; mem_rdy = 1; mem_rdata = 16'h1261;
        @(negedge clock);
        check("fetch_en", mem_en, 1'b1);
        check("fetch_addr", mem_addr, 16'h3000);
        @(negedge clock);
        check("fetch_en_drop", mem_en, 1'b0);
        check("fetch_ci", complete_instr, 1'b1);
        check("fetch_cd", complete_data, 1'b0);
        check("fetch_dout", Instr_dout, 16'h1261);
        instrmem_rd = 0; pc = 16'h0000;
        @(negedge clock);
        check("fetch_ci_clear", complete_instr, 1'b0);
        check("fetch_dout_hold", Instr_dout, 16'h1261);
        $display("[TB] txn fetch 3000 -> %h", Instr_dout);

        // Data write, memory ready after 3 cycles
        data_req = 1; Data_rd = 0; Data_addr = 16'h4010; Data_din = 16'hBEEF;
        mem_rdy = 0; mem_rdata = 16'h7777;
        we_cycles = 0; pulses = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (mem_en && mem_we && mem_addr == 16'h4010 && mem_wdata == 16'hBEEF) we_cycles++;
            pulses += int'(complete_data);
            if (i == 2) mem_rdy = 1;
        end
        @(negedge clock);
        pulses += int'(complete_data);
        check("write_we_drop", mem_we, 1'b0);
        data_req = 0; Data_addr = 16'h0000; Data_din = 16'h0000;
        @(negedge clock);
        pulses += int'(complete_data);
        check("write_we_cycles", we_cycles, 3);
        check("write_pulses", pulses, 1);
        check("write_dout_unchanged", Data_dout, 16'h0000);
        $display("[TB] txn write 4010 BEEF we_cycles=%0d", we_cycles);

        // Both requesters held: grant order D D D D I D D D D I
        instrmem_rd = 1; data_req = 1; Data_rd = 1; mem_rdy = 1; mem_rdata = 16'h0101;
        n_done = 0; order = '0;
        for (int i = 0; i < 200 && n_done < 10; i++) begin
            @(negedge clock);
            if (complete_instr || complete_data) begin
                order[n_done] = complete_instr;
                n_done++;
            end
        end
        instrmem_rd = 0; data_req = 0;
        check("streak_done", n_done, 10);
        check("streak_order", order, 10'b1000010000);
        @(negedge clock);
        $display("[TB] txn streak order=%b", order);

        // Address change after grant does not disturb the access
        data_req = 1; Data_rd = 1; Data_addr = 16'h0005; mem_rdy = 0; mem_rdata = 16'hA5A5;
        @(negedge clock);
        check("latch_en", mem_en, 1'b1);
        check("latch_addr0", mem_addr, 16'h0005);
        Data_addr = 16'h0009;
        @(negedge clock);
        check("latch_addr1", mem_addr, 16'h0005);
        mem_rdy = 1;
        @(negedge clock);
        check("latch_cd", complete_data, 1'b1);
        check("latch_dout", Data_dout, 16'hA5A5);
        data_req = 0;
        @(negedge clock);
        $display("[TB] txn latch addr 0005 -> %h", Data_dout);

        // Reset in the middle of a data access
        data_req = 1; Data_rd = 1; Data_addr = 16'h0123; mem_rdy = 0;
        @(negedge clock);
        check("mid_rst_en_before", mem_en, 1'b1);
        reset = 1;
        @(negedge clock);
        check("mid_rst_en", mem_en, 1'b0);
        check("mid_rst_cd", complete_data, 1'b0);
        check("mid_rst_outs", {mem_addr, Data_dout}, 32'h0);
        check("mid_rst_instr", {Instr_dout, mem_wdata}, 32'h0);
        reset = 0; data_req = 0;
        @(negedge clock);
        check("mid_rst_no_pulse", {complete_data, mem_en}, 2'b00);
        $display("[TB] txn reset during access");

`ifdef LC3_ARB_TIMEOUT_EN
        data_req = 1; Data_rd = 1; Data_addr = 16'h0042; mem_rdy = 0;
        en_cycles = 0; done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clock);
            if (complete_data) done = 1;
            else if (mem_en) en_cycles++;
        end
        check("tmo_done", done, 1'b1);
        check("tmo_cycles", en_cycles, TMO);
        check("tmo_dout", Data_dout, 16'hFFFF);
        check("tmo_err", arb_err, 1'b1);
        data_req = 0;
        repeat (5) @(negedge clock);
        check("tmo_err_sticky", arb_err, 1'b1);
        reset = 1;
        @(negedge clock);
        check("tmo_err_rst", arb_err, 1'b0);
        reset = 0;
        $display("[TB] txn timeout after %0d cycles", en_cycles);
`else
        en_cycles = 0; done = 0;
        $display("[TB] txn timeout feature disabled, arb_err=%0b", arb_err);
`endif

        // Randomized requesters and memory
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            if (complete_instr) instrmem_rd = 1'($urandom % 2);
            else if (!instrmem_rd) instrmem_rd = ($urandom % 3 == 0);
            else if ($urandom % 64 == 0) instrmem_rd = 0;
            if (complete_data) data_req = 1'($urandom % 2);
            else if (!data_req) data_req = ($urandom % 3 == 0);
            else if ($urandom % 64 == 0) data_req = 0;
            pc        = 16'($urandom);
            Data_addr = 16'($urandom);
            Data_din  = 16'($urandom);
            Data_rd   = 1'($urandom % 2);
            mem_rdy   = ($urandom % 4 != 0);
            mem_rdata = 16'($urandom);
            reset     = ($urandom % 400 == 0);
            if (complete_instr) $display("[TB] txn fetch done instr=%h", Instr_dout);
            if (complete_data)  $display("[TB] txn data done dout=%h", Data_dout);
        end
        reset = 0; instrmem_rd = 0; data_req = 0;
        repeat (4) @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
